// File: rtl/acc_adder16_recovery.sv
// Exact-sum checker for the approximate adder: captures a transaction, ripples the
// exact sum CHUNK bits per cycle, compares against the approximate sum and counts mismatches.
module acc_adder16_recovery #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  input  logic [WIDTH:0]   approx_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH:0]   result_o,
  output logic             err_o,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, CHECK, OUT} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   approx;
  } req_t;

  state_t           state_q;
  req_t             req_q;
  logic [WIDTH:0]   sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;
  logic             mismatch;

  always_comb begin
    chunk_sum  = {1'b0, req_q.a[idx_q*CHUNK +: CHUNK]}
               + {1'b0, req_q.b[idx_q*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (idx_q == IDX_W'(NCH - 1));
    mismatch   = (sum_q != req_q.approx);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ready_o   <= 1'b1;
      valid_o   <= 1'b0;
      result_o  <= '0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
      req_q     <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_o) begin
            req_q   <= '{a: add1_i, b: add2_i, approx: approx_i};
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            ready_o <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q <= chunk_sum[CHUNK];
          idx_q   <= idx_q + 1'b1;
          if (last_chunk) begin
            sum_q[WIDTH] <= chunk_sum[CHUNK];
            state_q      <= CHECK;
          end
        end
        CHECK: begin
          result_o <= sum_q;
          err_o    <= mismatch;
          if (mismatch && (err_cnt_o != '1))
            err_cnt_o <= err_cnt_o + 1'b1;
          valid_o  <= 1'b1;
          state_q  <= OUT;
        end
        OUT: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Clear overrides a same-cycle increment.
      if (clr_cnt_i)
        err_cnt_o <= '0;
    end
  end

endmodule
